// File: rtl/dps_pkg.sv
`default_nettype none
// =====================================================================
// dps_pkg : shared state encoding and default sizing for delay_path_sched
// Revision 1.0
// =====================================================================
package dps_pkg;

    localparam int c_npath_default   = 4;
    localparam int c_cnt_w_default   = 8;
    localparam int c_timeout_default = 200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } dps_state_e;

endpackage : dps_pkg
`default_nettype wire

// File: rtl/dps_sync2.sv
`default_nettype none
// =====================================================================
// dps_sync2 : two-flop synchronizer bank for asynchronous level inputs
// Revision 1.0
// =====================================================================
module dps_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule : dps_sync2
`default_nettype wire

// File: rtl/delay_path_sched.sv
`default_nettype none
// =====================================================================
// delay_path_sched : round-robin launcher that times one delay path at a
//                    time from its launch edge to the synchronised arrival.
// Revision 1.0
// =====================================================================
module delay_path_sched
    import dps_pkg::*;
#(
    parameter int NPATH   = c_npath_default,
    parameter int CNT_W   = c_cnt_w_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPATH-1:0]         req_i,
    output logic [NPATH-1:0]         gnt_o,
    output logic [NPATH-1:0]         launch_o,
    input  logic [NPATH-1:0]         arrive_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [$clog2(NPATH)-1:0] res_path_o,
    output logic [CNT_W-1:0]         res_cnt_o,
    output logic                     res_timeout_o,
    output logic                     busy_o
);

    localparam int               IDX_W         = $clog2(NPATH);
    localparam int               SUM_W         = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(NPATH - 1);
    localparam logic [SUM_W-1:0] c_npath_sum   = SUM_W'(NPATH);

    dps_state_e       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NPATH-1:0] launch_q, launch_d;
    logic             base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_to_q, res_to_d;

    logic [NPATH-1:0] arr_s;
    logic [SUM_W-1:0] w_cand_sum [NPATH];
    logic [IDX_W-1:0] w_cand     [NPATH];
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_rr_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_busy;

    dps_sync2 #(
        .WIDTH (NPATH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (arrive_i),
        .q_o   (arr_s)
    );

    // Candidate k is the path k places after the round-robin pointer.
    for (genvar gi = 0; gi < NPATH; gi++) begin : g_cand
        assign w_cand_sum[gi] = {1'b0, ptr_q} + SUM_W'(gi);
        assign w_cand[gi]     = (w_cand_sum[gi] >= c_npath_sum)
                              ? IDX_W'(w_cand_sum[gi] - c_npath_sum)
                              : w_cand_sum[gi][IDX_W-1:0];
    end

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        // Scan farthest first so the nearest requester overwrites the choice.
        for (int k = NPATH - 1; k >= 0; k--) begin
            if (req_i[w_cand[k]]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_cand[k];
            end
        end
    end

    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        launch_d  = launch_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        res_cnt_d = res_cnt_q;
        res_to_d  = res_to_q;

        case (state_q)
            ST_IDLE: begin
                if (w_rr_hit) begin
                    sel_d   = w_rr_idx;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                launch_d[sel_q] = ~launch_q[sel_q];
                base_d          = arr_s[sel_q];
                cnt_d           = '0;
                ptr_d           = (sel_q == c_last_idx) ? '0 : sel_q + 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = w_cnt_inc;
                // An arrival seen on the final cycle still wins over the abort.
                if (arr_s[sel_q] != base_q) begin
                    res_cnt_d = w_cnt_inc;
                    res_to_d  = 1'b0;
                    state_d   = ST_REPORT;
                end else if (w_cnt_inc == c_timeout_cnt) begin
                    res_cnt_d = c_timeout_cnt;
                    res_to_d  = 1'b1;
                    state_d   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            launch_q  <= '0;
            base_q    <= 1'b0;
            cnt_q     <= '0;
            res_cnt_q <= '0;
            res_to_q  <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            launch_q  <= launch_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            res_cnt_q <= res_cnt_d;
            res_to_q  <= res_to_d;
        end
    end

    assign w_busy = (state_q != ST_IDLE);

    for (genvar gi = 0; gi < NPATH; gi++) begin : g_gnt
        assign gnt_o[gi] = w_busy && (sel_q == IDX_W'(gi));
    end

    assign launch_o      = launch_q;
    assign res_valid_o   = (state_q == ST_REPORT);
    assign res_path_o    = sel_q;
    assign res_cnt_o     = res_cnt_q;
    assign res_timeout_o = res_to_q;
    assign busy_o        = w_busy;

endmodule : delay_path_sched
`default_nettype wire
